// File: rtl/cpu_pkg.sv
// Shared constants and write-back selector encodings for the single-cycle MIPS core.
package cpu_pkg;

  localparam int          DW       = 32;
  localparam int          AW       = 5;
  localparam logic [4:0]  REG_ZERO = 5'd0;
  localparam logic [4:0]  REG_RA   = 5'd31;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  typedef enum logic [1:0] {
    REGDST_RT = 2'b00,
    REGDST_RD = 2'b01,
    REGDST_RA = 2'b10
  } regDst_e;

  typedef enum logic [1:0] {
    MEMTOREG_ALU = 2'b00,
    MEMTOREG_MEM = 2'b01,
    MEMTOREG_PC4 = 2'b10
  } memToReg_e;

endpackage

// File: rtl/grf_trace.sv
// Commit-trace registers for the register file: one pulse per committed write,
// plus the PC/address/data of the last commit and a running commit count.
module grf_trace #(
  parameter int          DW       = cpu_pkg::DW,
  parameter int          AW       = cpu_pkg::AW,
  parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_commit,
  input  logic [31:0]   i_pc,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  output logic [31:0]   o_pc,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_data,
  output logic [31:0]   o_count
);

  logic          r_valid;
  logic [31:0]   r_pc;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic [31:0]   r_count;

  // Payload and count hold between commits; the count wraps naturally.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_pc    <= RESET_PC;
      r_addr  <= '0;
      r_data  <= '0;
      r_count <= '0;
    end else begin
      r_valid <= i_commit;
      if (i_commit) begin
        r_pc    <= i_pc;
        r_addr  <= i_addr;
        r_data  <= i_data;
        r_count <= r_count + 32'd1;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_addr  = r_addr;
  assign o_data  = r_data;
  assign o_count = r_count;

endmodule

// File: rtl/grf.sv
// 32 x 32-bit MIPS general register file with $0 hardwired to zero and a commit trace.
// Define GRF_BYPASS_EN to forward same-cycle write data onto the read ports.
module grf #(
  parameter int          DW       = cpu_pkg::DW,
  parameter int          AW       = cpu_pkg::AW,
  parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          WE,
  input  logic [AW-1:0] A1,
  input  logic [AW-1:0] A2,
  input  logic [AW-1:0] A3,
  input  logic [DW-1:0] WD,
  input  logic [31:0]   PC,
  output logic [DW-1:0] RD1,
  output logic [DW-1:0] RD2,
  output logic          tr_valid,
  output logic [31:0]   tr_pc,
  output logic [AW-1:0] tr_addr,
  output logic [DW-1:0] tr_data,
  output logic [31:0]   tr_count
);

  import cpu_pkg::*;

  localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

  logic [DW-1:0] r_regs [2**AW];
  logic          w_commit;
  logic [DW-1:0] w_rd1Array;
  logic [DW-1:0] w_rd2Array;

  assign w_commit = WE && (A3 != ZERO_ADDR);

  // Reset clears every entry so reads are never X; $0 is simply never written.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 2**AW; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_commit) begin
      r_regs[A3] <= WD;
    end
  end

  assign w_rd1Array = (A1 == ZERO_ADDR) ? '0 : r_regs[A1];
  assign w_rd2Array = (A2 == ZERO_ADDR) ? '0 : r_regs[A2];

`ifdef GRF_BYPASS_EN
  assign RD1 = (w_commit && (A1 == A3)) ? WD : w_rd1Array;
  assign RD2 = (w_commit && (A2 == A3)) ? WD : w_rd2Array;
`else
  assign RD1 = w_rd1Array;
  assign RD2 = w_rd2Array;
`endif

  grf_trace #(
    .DW       (DW),
    .AW       (AW),
    .RESET_PC (RESET_PC)
  ) u_trace (
    .clk      (clk),
    .reset    (reset),
    .i_commit (w_commit),
    .i_pc     (PC),
    .i_addr   (A3),
    .i_data   (WD),
    .o_valid  (tr_valid),
    .o_pc     (tr_pc),
    .o_addr   (tr_addr),
    .o_data   (tr_data),
    .o_count  (tr_count)
  );

endmodule

// File: tb/tb_grf.sv
// Self-checking bench for grf: directed vector table, hand-written corner sequences
// and randomized traffic against an array-based reference model.
module tb_grf;

  logic        clk = 1'b0;
  logic        reset;
  logic        WE;
  logic [4:0]  A1, A2, A3;
  logic [31:0] WD, PC;
  logic [31:0] RD1, RD2;
  logic        tr_valid;
  logic [31:0] tr_pc;
  logic [4:0]  tr_addr;
  logic [31:0] tr_data;
  logic [31:0] tr_count;

  int checkCount = 0;
  int passCount  = 0;

  logic [31:0] model [32];
  logic        expValid;
  logic [31:0] expPc, expData, expCount;
  logic [4:0]  expAddr;

  typedef struct {
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc;
    logic [4:0]  a1;
    logic [31:0] expRd1;
    logic        expValid;
    logic [31:0] expCount;
  } vec_t;

  vec_t vecs [5];

  grf dut (
    .clk      (clk),
    .reset    (reset),
    .WE       (WE),
    .A1       (A1),
    .A2       (A2),
    .A3       (A3),
    .WD       (WD),
    .PC       (PC),
    .RD1      (RD1),
    .RD2      (RD2),
    .tr_valid (tr_valid),
    .tr_pc    (tr_pc),
    .tr_addr  (tr_addr),
    .tr_data  (tr_data),
    .tr_count (tr_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: simulation did not finish (got running, need finished)");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Expected read value computed from the architectural rules, not the RTL.
  function automatic logic [31:0] expRead(input logic [4:0] addr);
    if (addr == 5'd0) return 32'd0;
`ifdef GRF_BYPASS_EN
    if (WE && addr == A3) return WD;
`endif
    return model[addr];
  endfunction

  // One rising edge: model follows the same sampled inputs, then settle for sampling.
  task automatic clockEdge();
    @(posedge clk);
    if (!reset) begin
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
      expValid = 1'b0; expPc = 32'h0000_3000; expAddr = 5'd0; expData = 32'd0; expCount = 32'd0;
    end else begin
      expValid = WE && (A3 != 5'd0);
      if (expValid) begin
        model[A3] = WD;
        expPc = PC; expAddr = A3; expData = WD; expCount = expCount + 32'd1;
      end
    end
    #1;
  endtask

  task automatic applyStimulus(input logic we, input logic [4:0] a1, input logic [4:0] a2,
                               input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] pc);
    WE = we; A1 = a1; A2 = a2; A3 = a3; WD = wd; PC = pc;
    #1;
  endtask

  task automatic checkTrace(input string tag);
    checkOutput({tag, ".tr_valid"}, {31'd0, tr_valid}, {31'd0, expValid});
    checkOutput({tag, ".tr_pc"}, tr_pc, expPc);
    checkOutput({tag, ".tr_addr"}, {27'd0, tr_addr}, {27'd0, expAddr});
    checkOutput({tag, ".tr_data"}, tr_data, expData);
    checkOutput({tag, ".tr_count"}, tr_count, expCount);
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd8,  32'hDEAD_BEEF, 32'h0000_3004, 5'd8,  32'hDEAD_BEEF, 1'b1, 32'd1};
    vecs[1] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 32'h0000_3008, 5'd0,  32'h0000_0000, 1'b0, 32'd1};
    vecs[2] = '{1'b0, 5'd9,  32'h0000_1234, 32'h0000_300C, 5'd9,  32'h0000_0000, 1'b0, 32'd1};
    vecs[3] = '{1'b1, 5'd31, 32'h0000_0001, 32'h0000_3010, 5'd31, 32'h0000_0001, 1'b1, 32'd2};
    vecs[4] = '{1'b1, 5'd8,  32'hCAFE_F00D, 32'h0000_3014, 5'd8,  32'hCAFE_F00D, 1'b1, 32'd3};

    reset = 1'b0;
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
    clockEdge();
    clockEdge();
    reset = 1'b1;

    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 5'(i), 5'(31 - i), 5'd0, 32'd0, 32'd0);
      checkOutput($sformatf("reset.RD1[%0d]", i), RD1, 32'd0);
      checkOutput($sformatf("reset.RD2[%0d]", 31 - i), RD2, 32'd0);
    end
    checkOutput("reset.tr_valid", {31'd0, tr_valid}, 32'd0);
    checkOutput("reset.tr_count", tr_count, 32'd0);
    checkOutput("reset.tr_pc", tr_pc, 32'h0000_3000);

    for (int v = 0; v < 5; v++) begin
      applyStimulus(vecs[v].we, 5'd0, 5'd0, vecs[v].a3, vecs[v].wd, vecs[v].pc);
      clockEdge();
      applyStimulus(1'b0, vecs[v].a1, 5'd0, 5'd0, 32'd0, 32'd0);
      checkOutput($sformatf("vec%0d.RD1", v), RD1, vecs[v].expRd1);
      checkOutput($sformatf("vec%0d.tr_valid", v), {31'd0, tr_valid}, {31'd0, vecs[v].expValid});
      checkOutput($sformatf("vec%0d.tr_count", v), tr_count, vecs[v].expCount);
      if (v == 0) begin
        checkOutput("vec0.tr_addr", {27'd0, tr_addr}, 32'd8);
        checkOutput("vec0.tr_data", tr_data, 32'hDEAD_BEEF);
        checkOutput("vec0.tr_pc", tr_pc, 32'h0000_3004);
      end
    end

    // Same-cycle read of the register being written: old value unless bypassed.
    applyStimulus(1'b1, 5'd31, 5'd31, 5'd31, 32'h0000_0002, 32'h0000_3018);
`ifdef GRF_BYPASS_EN
    checkOutput("rw31.RD2.pre", RD2, 32'h0000_0002);
    checkOutput("rw31.RD1.pre", RD1, 32'h0000_0002);
`else
    checkOutput("rw31.RD2.pre", RD2, 32'h0000_0001);
    checkOutput("rw31.RD1.pre", RD1, 32'h0000_0001);
`endif
    clockEdge();
    applyStimulus(1'b0, 5'd31, 5'd31, 5'd0, 32'd0, 32'd0);
    checkOutput("rw31.RD2.post", RD2, 32'h0000_0002);
    checkTrace("rw31");

    // Write coinciding with reset is dropped and everything clears.
    reset = 1'b0;
    applyStimulus(1'b1, 5'd5, 5'd8, 5'd5, 32'h0000_0055, 32'h0000_301C);
    clockEdge();
    reset = 1'b1;
    applyStimulus(1'b0, 5'd5, 5'd8, 5'd0, 32'd0, 32'd0);
    checkOutput("rstwr.reg5", RD1, 32'd0);
    checkOutput("rstwr.reg8", RD2, 32'd0);
    checkOutput("rstwr.tr_valid", {31'd0, tr_valid}, 32'd0);
    checkOutput("rstwr.tr_count", tr_count, 32'd0);
    checkOutput("rstwr.tr_pc", tr_pc, 32'h0000_3000);

    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, 5'd0, 5'd0, 5'((i % 31) + 1), $urandom, 32'h0000_4000 + 32'(4 * i));
      clockEdge();
      checkOutput($sformatf("burst%0d.tr_valid", i), {31'd0, tr_valid}, 32'd1);
      checkOutput($sformatf("burst%0d.tr_addr", i), {27'd0, tr_addr}, 32'((i % 31) + 1));
    end
    checkOutput("burst.tr_count", tr_count, 32'd40);
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 5'(i), 5'(i), 5'd0, 32'd0, 32'd0);
      checkOutput($sformatf("burst.reg%0d", i), RD1, expRead(5'(i)));
    end

    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), 5'($urandom), 5'($urandom),
                    5'($urandom), $urandom, $urandom);
      if (i % 7 == 3) A1 = A3;
      if (i % 11 == 5) A2 = A3;
      #1;
      checkOutput($sformatf("rnd%0d.RD1", i), RD1, expRead(A1));
      checkOutput($sformatf("rnd%0d.RD2", i), RD2, expRead(A2));
      reset = ($urandom_range(0, 49) != 0);
      clockEdge();
      reset = 1'b1;
      checkTrace($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
